// File: rtl/dht11_reader_if.sv
// Result/status bundle from the DHT11 reader to its consumer.
interface dht11_reader_if;
   logic        done;
   logic [31:0] raw_data;
   logic        data_valid;
   logic        chk_err;
   logic        timeout_err;
   logic        busy;

   modport master (output done, raw_data, data_valid, chk_err, timeout_err, busy);
   modport slave  (input  done, raw_data, data_valid, chk_err, timeout_err, busy);
endinterface

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: periodic start pulse, 40-bit frame capture, checksum check.
// state     | meaning
// IDLE      | bus released, waiting for the period counter to wrap
// START_LOW | host holds the bus low for START_CYC cycles
// REL_WAIT  | bus released, waiting for the sensor to pull low
// RESP_LOW  | sensor response low phase
// RESP_HIGH | sensor response high phase
// BIT_LOW   | low preamble of a data bit
// BIT_HIGH  | measuring the high time of a data bit
// CHECK     | checksum compare and result publish
module dht11_reader #(
   parameter int START_CYC   = 216000,
   parameter int THRESH_CYC  = 480,
   parameter int TIMEOUT_CYC = 1440,
   parameter int PERIOD_CYC  = 24000000
) (
   input  logic           clk,
   input  logic           reset,
   inout  wire            dht_data,
   dht11_reader_if.master res
);
   localparam int TMR_MAX = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int HI_W    = $clog2(TIMEOUT_CYC + 1);
   localparam int PER_W   = $clog2(PERIOD_CYC);

   localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_CYC - 1);
   localparam logic [TMR_W-1:0] WAIT_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD_CYC - 1);
   localparam logic [HI_W-1:0]  HI_THRESH  = HI_W'(THRESH_CYC);

   typedef enum logic [2:0] {
      IDLE, START_LOW, REL_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
   } state_t;

   state_t            state_q;
   logic [2:0]        sync_q;
   logic              drive_q;
   logic [TMR_W-1:0]  tmr_q;
   logic [HI_W-1:0]   hi_cnt_q;
   logic [5:0]        bit_cnt_q;
   logic [39:0]       shift_q;
   logic [PER_W-1:0]  per_cnt_q;
   logic              done_q;
   logic [31:0]       raw_q;
   logic              dv_q;
   logic              chk_q;
   logic              to_q;
   logic              busy_q;

   logic              rise;
   logic              fall;
   logic              per_wrap;
   logic              wait_st;
   logic              evt;
   logic              bit_val;
   logic [7:0]        sum8;

   assign dht_data = drive_q ? 1'b0 : 1'bz;

   // sync_q[1] is the synchronized bus; sync_q[2] is its previous value for edges
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 3'b111;
      else       sync_q <= {sync_q[1:0], dht_data};
   end

   assign rise     = sync_q[1] & ~sync_q[2];
   assign fall     = ~sync_q[1] & sync_q[2];
   assign per_wrap = (per_cnt_q == PER_LAST);
   assign wait_st  = (state_q == REL_WAIT) || (state_q == RESP_LOW) || (state_q == RESP_HIGH) ||
                     (state_q == BIT_LOW)  || (state_q == BIT_HIGH);
   assign bit_val  = (hi_cnt_q > HI_THRESH);
   assign sum8     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

   always_comb begin
      evt = 1'b0;
      case (state_q)
         REL_WAIT:  evt = fall;
         RESP_LOW:  evt = rise;
         RESP_HIGH: evt = fall;
         BIT_LOW:   evt = rise;
         BIT_HIGH:  evt = fall;
         default:   evt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         drive_q   <= 1'b0;
         tmr_q     <= '0;
         hi_cnt_q  <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         per_cnt_q <= '0;
         done_q    <= 1'b0;
         raw_q     <= '0;
         dv_q      <= 1'b0;
         chk_q     <= 1'b0;
         to_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         dv_q      <= 1'b0;
         chk_q     <= 1'b0;
         to_q      <= 1'b0;
         per_cnt_q <= per_wrap ? '0 : per_cnt_q + 1'b1;

         if (wait_st && !evt) begin
            // one shared down-counter, reloaded on every wait-state entry
            if (tmr_q == '0) begin
               to_q    <= 1'b1;
               drive_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end else begin
               tmr_q <= tmr_q - 1'b1;
            end
            if (state_q == BIT_HIGH) hi_cnt_q <= hi_cnt_q + 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (per_wrap) begin
                     drive_q <= 1'b1;
                     busy_q  <= 1'b1;
                     tmr_q   <= START_LOAD;
                     state_q <= START_LOW;
                  end
               end
               START_LOW: begin
                  if (tmr_q == '0) begin
                     drive_q <= 1'b0;
                     tmr_q   <= WAIT_LOAD;
                     state_q <= REL_WAIT;
                  end else begin
                     tmr_q <= tmr_q - 1'b1;
                  end
               end
               REL_WAIT: begin
                  tmr_q   <= WAIT_LOAD;
                  state_q <= RESP_LOW;
               end
               RESP_LOW: begin
                  tmr_q   <= WAIT_LOAD;
                  state_q <= RESP_HIGH;
               end
               RESP_HIGH: begin
                  tmr_q     <= WAIT_LOAD;
                  bit_cnt_q <= '0;
                  state_q   <= BIT_LOW;
               end
               BIT_LOW: begin
                  tmr_q    <= WAIT_LOAD;
                  hi_cnt_q <= '0;
                  state_q  <= BIT_HIGH;
               end
               BIT_HIGH: begin
                  shift_q <= {shift_q[38:0], bit_val};
                  tmr_q   <= WAIT_LOAD;
                  if (bit_cnt_q == 6'd39) begin
                     state_q <= CHECK;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     state_q   <= BIT_LOW;
                  end
               end
               CHECK: begin
                  if (sum8 == shift_q[7:0]) begin
                     raw_q  <= shift_q[39:8];
                     done_q <= 1'b1;
                     dv_q   <= 1'b1;
                  end else begin
                     chk_q <= 1'b1;
                  end
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  drive_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign res.done        = done_q;
   assign res.raw_data    = raw_q;
   assign res.data_valid  = dv_q;
   assign res.chk_err     = chk_q;
   assign res.timeout_err = to_q;
   assign res.busy        = busy_q;
endmodule

// File: doc/dht11_reader.md
DHT11_READER -- requirements
Module: dht11_reader

Interface
REQ-001 Parameter START_CYC, default 216000, host start-pulse low time in clk cycles (18 ms at 12 MHz).
REQ-002 Parameter THRESH_CYC, default 480, data-bit high-time threshold in cycles (40 us).
REQ-003 Parameter TIMEOUT_CYC, default 1440, maximum cycles spent in any sensor-wait state (120 us).
REQ-004 Parameter PERIOD_CYC, default 24000000, cycles between the starts of successive reads (2 s).
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 dht_data  inout  1  DHT11 single-wire bus; block drives 0 or releases to 'z', never drives 1.
REQ-008 done  output  1  level; high once any frame with valid checksum has been captured.
REQ-009 raw_data  output  32  {hum_int, hum_dec, temp_int, temp_dec} of last valid frame.
REQ-010 data_valid  output  1  one-cycle pulse when raw_data is updated.
REQ-011 chk_err  output  1  one-cycle pulse on checksum mismatch.
REQ-012 timeout_err  output  1  one-cycle pulse on any wait-state timeout.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 dht_data input passes through a 2-flop synchronizer; all edge detection uses the synchronized value.
REQ-015 States: IDLE, START_LOW, REL_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-016 IDLE: bus released; period counter counts to PERIOD_CYC-1, then clears and enters START_LOW.
REQ-017 START_LOW: bus driven 0 for exactly START_CYC cycles, then released and REL_WAIT entered.
REQ-018 REL_WAIT: wait for synchronized low; then RESP_LOW.
REQ-019 RESP_LOW: wait for high; then RESP_HIGH.
REQ-020 RESP_HIGH: wait for low; then BIT_LOW with bit counter 0.
REQ-021 BIT_LOW: wait for high; then BIT_HIGH with high-time counter cleared.
REQ-022 BIT_HIGH: count cycles while high; on falling edge shift in bit = (count > THRESH_CYC), MSB first; after bit 39 go to CHECK, else BIT_LOW.
REQ-023 Every wait state (REL_WAIT..BIT_HIGH) has its own cycle counter cleared on entry; reaching TIMEOUT_CYC pulses timeout_err, releases bus, returns to IDLE; raw_data and done unchanged.
REQ-024 CHECK (one cycle): if (b0+b1+b2+b3) mod 256 == b4, load raw_data, set done, pulse data_valid; else pulse chk_err, raw_data unchanged; then IDLE.
REQ-025 Period counter runs in all states, so read starts are PERIOD_CYC apart regardless of outcome.
REQ-026 done, once set, stays high until reset; failed reads never clear it.
REQ-027 raw_data updates atomically in one cycle; partial frames never visible.
REQ-028 Bit counter 6 bits, high-time counter wide enough for TIMEOUT_CYC; 40-bit shift register.

Reset
REQ-029 Reset asserted: state IDLE, bus released, done=0, raw_data=0, data_valid=chk_err=timeout_err=0, busy=0, all counters 0.
REQ-030 First read starts PERIOD_CYC cycles after reset deassertion (sensor power-up settle).
REQ-031 Reset mid-frame aborts immediately: bus released same cycle, no pulse outputs, raw_data cleared.

Verification
REQ-032 Bench parameters START_CYC=20, THRESH_CYC=8, TIMEOUT_CYC=30, PERIOD_CYC=2000.
REQ-033 Model sends 0x37,0x00,0x19,0x00,0x50 (bit 0 high 4 cycles, bit 1 high 14) -> raw_data=0x37001900, done=1, one data_valid pulse.
REQ-034 Same frame with checksum 0x51 -> chk_err pulse, raw_data and done unchanged.
REQ-035 No sensor response after release -> timeout_err pulse exactly 30 cycles into REL_WAIT, bus released, next start 2000 cycles after previous.
REQ-036 Bus stuck high mid-bit 17 -> timeout_err, prior raw_data retained, done retained.
REQ-037 Reset asserted during bit 20 -> bus 'z' same cycle, done=0, raw_data=0, next start pulse 2000 cycles after release.
